// File: rtl/delay_line_pkg.sv
// Shared types for the circular delay-line sequencer and its RAM.
package delay_line_pkg;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_OUT
    } dl_state_t;

endpackage

// File: rtl/block_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-before-write.
module block_ram #(
    parameter int unsigned W = 24,
    parameter int unsigned L = 1024,
    localparam int unsigned AW = $clog2(L)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o,
    input  logic          wr_ena_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i
);

    logic [W-1:0] mem_q [L];
    logic [W-1:0] rd_data_q;

    // Non-blocking read and write on the same edge yield the old word on an address clash.
    always_ff @(posedge clk_i) begin
        if (wr_ena_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/delay_line_ctrl.sv
// Sequencer turning a dual-port block_ram into a circular audio delay line,
// with zero-fill after reset or on a clear pulse.
module delay_line_ctrl
    import delay_line_pkg::*;
#(
    parameter int unsigned W = 24,
    parameter int unsigned L = 1024,
    localparam int unsigned AW = $clog2(L)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic [AW-1:0] delay_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [W-1:0]  in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [W-1:0]  out_data_o,
    output logic          busy_o,
    output logic [AW-1:0] ram_rd_addr_o,
    input  logic [W-1:0]  ram_rd_data_i,
    output logic          ram_wr_ena_o,
    output logic [AW-1:0] ram_wr_addr_o,
    output logic [W-1:0]  ram_wr_data_o
);

    dl_state_t     state_q;
    logic [AW-1:0] clr_addr_q;
    logic [AW-1:0] wr_ptr_q;
    logic          out_valid_q;
    logic [W-1:0]  out_data_q;

    logic clearing;
    logic accept;

    assign clearing   = (state_q == S_CLEAR);
    assign in_ready_o = (state_q == S_IDLE) && !clear_i;
    assign accept     = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_CLEAR;
            clr_addr_q  <= '0;
            wr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (clear_i) begin
            // Flush wins over any handshake in the same cycle; a pending output is dropped.
            state_q     <= S_CLEAR;
            clr_addr_q  <= '0;
            wr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_CLEAR: begin
                    clr_addr_q <= clr_addr_q + AW'(1);
                    if (clr_addr_q == AW'(L - 1)) begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                        state_q  <= S_READ;
                    end
                end
                S_READ: begin
                    out_data_q  <= ram_rd_data_i;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    assign busy_o      = clearing;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

    // Reset holds the state at S_CLEAR, so the fill write is gated until reset is released.
    assign ram_wr_ena_o  = (clearing && rst_ni) || accept;
    assign ram_wr_addr_o = clearing ? clr_addr_q : wr_ptr_q;
    assign ram_wr_data_o = clearing ? '0 : in_data_i;
    // Wraps naturally at AW bits; delay 0 aliases the write address for a full-L delay.
    assign ram_rd_addr_o = wr_ptr_q - delay_i;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl paired with block_ram (W=16, L=16), scoreboard-checked.
module tb_delay_line_ctrl;

    localparam int unsigned W  = 16;
    localparam int unsigned L  = 16;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic [AW-1:0] dly;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;
    logic [AW-1:0] ram_rd_addr;
    logic [W-1:0]  ram_rd_data;
    logic          ram_wr_ena;
    logic [AW-1:0] ram_wr_addr;
    logic [W-1:0]  ram_wr_data;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mem_m [L];
    int           wp_m;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] last_out;

    always #5 clk = ~clk;

    delay_line_ctrl #(.W(W), .L(L)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .delay_i      (dly),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .busy_o       (busy),
        .ram_rd_addr_o(ram_rd_addr),
        .ram_rd_data_i(ram_rd_data),
        .ram_wr_ena_o (ram_wr_ena),
        .ram_wr_addr_o(ram_wr_addr),
        .ram_wr_data_o(ram_wr_data)
    );

    block_ram #(.W(W), .L(L)) u_ram (
        .clk_i    (clk),
        .rd_addr_i(ram_rd_addr),
        .rd_data_o(ram_rd_data),
        .wr_ena_i (ram_wr_ena),
        .wr_addr_i(ram_wr_addr),
        .wr_data_i(ram_wr_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(L); i++) mem_m[i] = '0;
        wp_m = 0;
        exp_q.delete();
    endtask

    // Entered just after the edge that starts a fill; checks all L zero writes.
    task automatic wait_fill();
        for (int i = 0; i < int'(L); i++) begin
            @(negedge clk);
            check("fill_busy", 32'(busy), 32'd1);
            check("fill_wr_ena", 32'(ram_wr_ena), 32'd1);
            check("fill_wr_addr", 32'(ram_wr_addr), 32'(i));
            check("fill_wr_data", 32'(ram_wr_data), 32'd0);
            check("fill_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        check("fill_done_busy", 32'(busy), 32'd0);
        check("fill_done_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        model_clear();
        wait_fill();
    endtask

    task automatic send_start(input logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
        exp_q.push_back(mem_m[(wp_m - int'(dly)) & (int'(L) - 1)]);
        mem_m[wp_m] = d;
        wp_m = (wp_m + 1) & (int'(L) - 1);
        @(negedge clk);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic send_finish(input int hold);
        logic [W-1:0] held;
        logic [W-1:0] exp;
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(held));
            check("stall_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        check("out_in_ready", 32'(in_ready), 32'd0);
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("out_data", 32'(out_data), 32'(exp));
        last_out = out_data;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input int hold);
        send_start(d);
        send_finish(hold);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        dly       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        last_out  = '0;
        model_clear();

        // Reset values and fill after release
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_wr_ena", 32'(ram_wr_ena), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_fill();

        // delay=3: 1..5 -> 0,0,0,1,2
        dly = 4'd3;
        for (int n = 1; n <= 5; n++) begin
            send(16'(n), 0);
            check("d3_out", 32'(last_out), (n > 3) ? 32'(n - 3) : 32'd0);
        end

        // delay=0 is a full-L delay; one output stalled for 10 cycles
        do_clear();
        dly = 4'd0;
        for (int n = 1; n <= 20; n++) begin
            send(16'(n), (n == 18) ? 10 : 0);
            check("d0_out", 32'(last_out), (n > 16) ? 32'(n - 16) : 32'd0);
        end

        // Clear with a pending output and a same-cycle out handshake
        do_clear();
        dly = 4'd3;
        for (int n = 1; n <= 4; n++) send(16'(n + 100), 0);
        send_start(16'd105);
        clear     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        out_ready = 1'b0;
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_busy", 32'(busy), 32'd1);
        model_clear();
        wait_fill();
        for (int n = 1; n <= 3; n++) begin
            send(16'(n + 200), 0);
            check("post_clr_out", 32'(last_out), 32'd0);
        end

        // delay=15 across several pointer wraps
        do_clear();
        dly = 4'd15;
        for (int n = 1; n <= 40; n++) begin
            send(16'(n), 0);
            check("d15_out", 32'(last_out), (n > 15) ? 32'(n - 15) : 32'd0);
        end

        // Asynchronous reset while an output is pending
        send_start(16'h0abc);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_busy", 32'(busy), 32'd1);
        check("arst_wr_ena", 32'(ram_wr_ena), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
        wait_fill();
        send(16'h0777, 0);
        check("after_arst_out", 32'(last_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
